// File: rtl/dmem_pkg.sv
// dmem_pkg: memory command codes and arbiter state encoding shared by the dmem arbiter files
package dmem_pkg;
  localparam logic [7:0] CMD_READ = 8'h00;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_IDLE = 8'hFF;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: fixed priority to requester 0 unless requester 1 has starved long enough
module dmem_arb_pick (
  input  logic r0_req,
  input  logic r1_req,
  input  logic wait_max,
  output logic valid,
  output logic id
);
  assign valid = r0_req | r1_req;
  assign id = r1_req & (wait_max | ~r0_req);
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data memory between the control unit (r0) and loader/debug port (r1)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int MEM_LAT = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_done,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_done,
  output logic [DW-1:0] r1_rdata,
  output logic [7:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  localparam int WW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  logic [1:0] state_q, state_d;
  logic we_q, we_d, id_q, id_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [7:0] mem_cmd_q, mem_cmd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d, r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
  logic r0_gnt_q, r0_gnt_d, r1_gnt_q, r1_gnt_d, r0_done_q, r0_done_d, r1_done_q, r1_done_d;
  logic busy_q, busy_d;
  logic pick_valid, pick_id, wait_max;
  assign wait_max = wait_cnt_q == WW'(MAX_WAIT);
  dmem_arb_pick u_pick (
    .r0_req  (r0_req),
    .r1_req  (r1_req),
    .wait_max(wait_max),
    .valid   (pick_valid),
    .id      (pick_id)
  );
  // mem_addr/mem_wdata double as the latched winner fields, so they hold through WAIT and DONE
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    id_d = id_q;
    wait_cnt_d = wait_cnt_q;
    lat_cnt_d = lat_cnt_q;
    mem_cmd_d = CMD_IDLE;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    r0_gnt_d = 1'b0;
    r1_gnt_d = 1'b0;
    r0_done_d = 1'b0;
    r1_done_d = 1'b0;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    if (state_q == IDLE || state_q == DONE) begin
      state_d = pick_valid ? ISSUE : IDLE;
      if (pick_valid) begin
        id_d = pick_id;
        we_d = pick_id ? r1_we : r0_we;
        mem_addr_d = pick_id ? r1_addr : r0_addr;
        mem_wdata_d = pick_id ? r1_wdata : r0_wdata;
        mem_cmd_d = we_d ? CMD_WRITE : CMD_READ;
        r0_gnt_d = ~pick_id;
        r1_gnt_d = pick_id;
        wait_cnt_d = pick_id ? '0 : (r1_req && !wait_max) ? wait_cnt_q + 1'b1 : wait_cnt_q;
      end
    end else if (state_q == ISSUE) begin
      state_d = WAIT;
      lat_cnt_d = LW'(MEM_LAT - 1);
    end else if (lat_cnt_q == '0) begin
      state_d = DONE;
      r0_done_d = ~id_q;
      r1_done_d = id_q;
      r0_rdata_d = id_q ? r0_rdata_q : (we_q ? '0 : mem_rdata);
      r1_rdata_d = id_q ? (we_q ? '0 : mem_rdata) : r1_rdata_q;
    end else begin
      lat_cnt_d = lat_cnt_q - 1'b1;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q <= 1'b0;
      id_q <= 1'b0;
      wait_cnt_q <= '0;
      lat_cnt_q <= '0;
      mem_cmd_q <= CMD_IDLE;
      mem_addr_q <= '0;
      mem_wdata_q <= '0;
      r0_gnt_q <= 1'b0;
      r1_gnt_q <= 1'b0;
      r0_done_q <= 1'b0;
      r1_done_q <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      id_q <= id_d;
      wait_cnt_q <= wait_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      mem_cmd_q <= mem_cmd_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      r0_gnt_q <= r0_gnt_d;
      r1_gnt_q <= r1_gnt_d;
      r0_done_q <= r0_done_d;
      r1_done_q <= r1_done_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
      busy_q <= busy_d;
    end
  end
  assign r0_gnt = r0_gnt_q;
  assign r1_gnt = r1_gnt_q;
  assign r0_done = r0_done_q;
  assign r1_done = r1_done_q;
  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;
  assign mem_cmd = mem_cmd_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of the dmem arbiter with MEM_LAT=1 and a MEM_LAT=3 second instance
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic r0_req, r0_we, r1_req, r1_we;
  logic [7:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic r0_gnt, r0_done, r1_gnt, r1_done, busy;
  logic [7:0] r0_rdata, r1_rdata, mem_cmd, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] mem [256];
  logic r0_req3;
  logic r0_gnt3, r0_done3, r1_gnt3, r1_done3, busy3;
  logic [7:0] r0_rdata3, r1_rdata3, mem_cmd3, mem_addr3, mem_wdata3;
  int errors = 0;
  int checks = 0;
  int n;
  always #5 clk = ~clk;
  dmem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_rdata(r1_rdata),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy)
  );
  dmem_arbiter #(.MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .r0_req(r0_req3), .r0_we(1'b0), .r0_addr(8'h44), .r0_wdata(8'h00),
    .r0_gnt(r0_gnt3), .r0_done(r0_done3), .r0_rdata(r0_rdata3),
    .r1_req(1'b0), .r1_we(1'b0), .r1_addr(8'h00), .r1_wdata(8'h00),
    .r1_gnt(r1_gnt3), .r1_done(r1_done3), .r1_rdata(r1_rdata3),
    .mem_cmd(mem_cmd3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_rdata(8'h5A),
    .busy(busy3)
  );
  // one-cycle-latency memory model; location 8'h10 preloads with 8'hA5
  always @(posedge clk) begin
    if (rst) mem[8'h10] <= 8'hA5;
    else if (mem_cmd == 8'h01) mem[mem_addr] <= mem_wdata;
    if (mem_cmd == 8'h00) mem_rdata <= mem[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    {r0_req, r0_we, r1_req, r1_we, r0_req3} = '0;
    {r0_addr, r0_wdata, r1_addr, r1_wdata} = '0;
    tick; tick;
    chk("rst_cmd", mem_cmd, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {r0_gnt, r1_gnt, r0_done, r1_done}, 0);
    chk("rst_rdata", {r0_rdata, r1_rdata}, 0);
    chk("rst_addr", {mem_addr, mem_wdata}, 0);
    chk("rst_cmd3", mem_cmd3, 8'hFF);
    rst = 1'b0;
    tick;
    r0_req = 1; r0_we = 0; r0_addr = 8'h10;
    tick;
    chk("t1_gnt", {r0_gnt, r1_gnt}, 2'b10);
    chk("t1_cmd", mem_cmd, 8'h00);
    chk("t1_addr", mem_addr, 8'h10);
    chk("t1_busy", busy, 1);
    r0_req = 0;
    tick;
    chk("t1_wait", {r0_gnt, r0_done, mem_cmd}, {2'b00, 8'hFF});
    tick;
    chk("t1_done", {r0_done, r1_done}, 2'b10);
    chk("t1_rdata", r0_rdata, 8'hA5);
    tick;
    chk("t1_idle", {busy, r0_done}, 0);
    r1_req = 1; r1_we = 1; r1_addr = 8'h20; r1_wdata = 8'h3C;
    tick;
    chk("t2w_gnt", {r0_gnt, r1_gnt}, 2'b01);
    chk("t2w_cmd", mem_cmd, 8'h01);
    chk("t2w_addr", {mem_addr, mem_wdata}, {8'h20, 8'h3C});
    r1_req = 0; r1_we = 0;
    tick; tick;
    chk("t2w_done", {r0_done, r1_done}, 2'b01);
    chk("t2w_rdata", r1_rdata, 8'h00);
    tick;
    r1_req = 1;
    tick;
    chk("t2r_cmd", {r1_gnt, mem_cmd}, {1'b1, 8'h00});
    r1_req = 0;
    tick; tick;
    chk("t2r_done", {r0_done, r1_done}, 2'b01);
    chk("t2r_rdata", r1_rdata, 8'h3C);
    chk("t2r_r0hold", r0_rdata, 8'hA5);
    tick;
    r0_req = 1; r0_addr = 8'h10; r1_req = 1; r1_addr = 8'h20;
    n = 0;
    for (int c = 0; c < 40 && n < 10; c++) begin
      tick;
      if (r0_gnt || r1_gnt) begin
        chk("t3_order", r1_gnt, (n % 5) == 4);
        chk("t3_onehot", r0_gnt & r1_gnt, 0);
        n++;
      end else if (n > 0) begin
        chk("t3_busy", busy, 1);
      end
    end
    chk("t3_count", n, 10);
    r0_req = 0; r1_req = 0;
    tick; tick; tick;
    chk("t3_idle", busy, 0);
    r0_req = 1; r0_addr = 8'h10; r1_req = 1; r1_addr = 8'h20;
    tick;
    chk("t4_gnt0", {r0_gnt, r1_gnt}, 2'b10);
    r0_req = 0;
    tick; tick;
    chk("t4_done0", {r0_done, r1_done, busy}, 3'b101);
    chk("t4_rdata0", r0_rdata, 8'hA5);
    tick;
    chk("t4_gnt1", {r0_gnt, r1_gnt, busy}, 3'b011);
    chk("t4_addr1", mem_addr, 8'h20);
    r1_req = 0;
    tick; tick;
    chk("t4_done1", {r0_done, r1_done}, 2'b01);
    chk("t4_rdata1", r1_rdata, 8'h3C);
    tick;
    r0_req = 1; r0_addr = 8'h10;
    tick;
    chk("t5_gnt", r0_gnt, 1);
    r0_req = 0;
    tick;
    rst = 1;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_cmd", mem_cmd, 8'hFF);
    chk("t5_rst_out", {mem_addr, r0_rdata}, 0);
    tick;
    chk("t5_nodone", {r0_done, r1_done}, 0);
    rst = 0;
    tick;
    chk("t5_nodone2", {r0_done, r1_done, busy}, 0);
    r0_req = 1; r0_addr = 8'h20;
    tick;
    chk("t5_gnt2", {r0_gnt, mem_cmd}, {1'b1, 8'h00});
    r0_req = 0;
    tick; tick;
    chk("t5_done2", r0_done, 1);
    chk("t5_rdata2", r0_rdata, 8'h3C);
    tick;
    r0_req3 = 1;
    for (int k = 1; k <= 6; k++) begin
      tick;
      if (k == 1) r0_req3 = 0;
      chk("t6_gnt", r0_gnt3, k == 1);
      chk("t6_cmd", mem_cmd3, (k == 1) ? 8'h00 : 8'hFF);
      chk("t6_done", r0_done3, k == 5);
      if (k == 5) chk("t6_rdata", r0_rdata3, 8'h5A);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported 8-bit data memory between two requesters.
- Requester 0 is the control unit (load/store micro-ops); requester 1 is the program-loader/debug port.
- Fixed priority to requester 0, with a starvation limit that forces a grant to requester 1.
- Each requester sees a req/gnt/done handshake; the memory side sees a one-cycle command pulse using the memory's 8-bit command codes.

Parameters:
- AW, 8, address width
- DW, 8, data width
- MEM_LAT, 1, cycles from command cycle to mem_rdata valid (>=1)
- MAX_WAIT, 4, lost arbitrations before requester 1 is forced to win (0 = requester 1 always wins ties)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous and active-high
- r0_req  in  1  requester 0 access request
- r0_we  in  1  1=write, 0=read
- r0_addr  in  AW  address
- r0_wdata  in  DW  write data
- r0_gnt  out  1  one-cycle grant pulse
- r0_done  out  1  one-cycle completion pulse
- r0_rdata  out  DW  read data, valid when r0_done=1
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_done, r1_rdata: same as r0_*, for requester 1
- mem_cmd  out  8  8'h00 read, 8'h01 write, 8'hFF idle
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, mem_cmd=8'hFF, mem_addr=0, mem_wdata=0, all gnt/done=0, rdata=0, wait_cnt=0, busy=0.
- Reset asserted mid-operation: the in-flight access is dropped and no done is issued. A write already presented to memory is not undone.
- States: IDLE, ISSUE, WAIT, DONE.
- Arbitration (in IDLE and DONE):
  - r1 wins if r1_req and (wait_cnt==MAX_WAIT or !r0_req).
  - Otherwise r0 wins if r0_req.
- wait_cnt:
  - increments when r0 is granted while r1_req=1; saturates at MAX_WAIT;
  - clears when r1 is granted.
  - Width is $clog2(MAX_WAIT+1), minimum 1.
- On a win, the winner's we/addr/wdata/id are latched; next state is ISSUE.
- ISSUE (exactly 1 cycle):
  - winner's gnt=1;
  - mem_cmd = 8'h01 if we else 8'h00; mem_addr and mem_wdata driven from the latched fields.
  - Next state is WAIT with lat_cnt=MEM_LAT-1.
- WAIT:
  - mem_cmd=8'hFF; mem_addr/mem_wdata hold.
  - Decrements lat_cnt; at lat_cnt==0, registers mem_rdata for reads (0 for writes) and moves to DONE.
- DONE (1 cycle):
  - winner's done=1 with rdata valid;
  - arbitrates the same cycle and goes to ISSUE if any req, else IDLE.
- Latency: req first seen in IDLE at cycle 0 -> gnt/mem_cmd at cycle 1 -> mem_rdata sampled at end of cycle 1+MEM_LAT -> done at cycle 2+MEM_LAT.
- Back-to-back throughput is one access per MEM_LAT+2 cycles.
- Handshake rules:
  - A requester holds req and its fields stable until gnt. Fields may change after gnt.
  - req still high in the done cycle counts as a new request.
  - req dropped before gnt withdraws the request; no done is issued.
- The loser's gnt stays 0.
- rdata of the non-winning port holds its previous value.
- The done pulse goes only to the latched winner, never to both ports.

Decomposition:
- Package dmem_pkg holds:
  - CMD_READ=8'h00, CMD_WRITE=8'h01, CMD_IDLE=8'hFF;
  - the state encoding IDLE/ISSUE/WAIT/DONE (2-bit).
- One sub-module is natural: dmem_arb_pick.
  - Combinational priority/starvation picker.
  - Inputs r0_req, r1_req, wait_cnt==MAX_WAIT; outputs valid and winner id.

Test Plan:
- r0 read addr 8'h10 (memory holds 8'hA5), MEM_LAT=1 -> r0_gnt at cycle 1, mem_cmd=8'h00 and mem_addr=8'h10 at cycle 1, r0_done with r0_rdata=8'hA5 at cycle 3.
- r1 write 8'h3C to 8'h20, then r1 read 8'h20 -> mem_cmd=8'h01 with mem_wdata=8'h3C; the read returns 8'h3C; r1_done pulses twice, r0_done never pulses.
- r0 and r1 requesting continuously, MAX_WAIT=4 -> grant order r0,r0,r0,r0,r1 repeating; wait_cnt returns to 0 after each r1 grant.
- r0 and r1 request in the same cycle with wait_cnt=0 -> r0 granted, r1 held off until DONE; r1 is granted next with no IDLE cycle between.
- rst asserted in WAIT -> immediate mem_cmd=8'hFF, busy=0, no done pulse; a new r0 request after release completes normally.
- MEM_LAT=3 build -> done exactly 5 cycles after the first req cycle; mem_cmd active for exactly 1 cycle.
